spi_byte_sequencer: RTL and testbench
=====================================

# spi_byte_sequencer

Command/frame controller between the SPI byte receiver and the LED pixel RAM. Consumes the receiver's one-cycle `byte_rdy`/`byte_data` stream and decodes a leading command byte. It then routes the payload either to a configuration register write port or to sequential pixel-RAM writes, and signals when a full pixel frame has been loaded. All state lives in the `clk_in` domain and is cleared whenever chip-select deasserts.

## Interface

**Parameters**
- `RAM_DEPTH`, default 768 — pixel RAM bytes (256 LEDs × 3); must be ≤ 2^`ADDR_WIDTH`.
- `ADDR_WIDTH`, default 10 — pixel RAM address width.

**Ports**
- `clk_in` in 1 — system clock.
- `spi_rst_n` in 1 — reset, asynchronous, active-low (the CS-gated SPI reset); clock `clk_in`.
- `byte_rdy_in` in 1 — one-cycle pulse: `byte_data_in` valid.
- `byte_data_in` in 8 — received byte.
- `cfg_wr_out` out 1 — one-cycle config write strobe.
- `cfg_data_out` out 8 — config byte; holds its value until the next `cfg_wr_out`.
- `ram_wr_en_out` out 1 — one-cycle pixel RAM write strobe.
- `ram_wr_addr_out` out `ADDR_WIDTH` — pixel RAM write address.
- `ram_wr_data_out` out 8 — pixel RAM write data.
- `frame_rdy_out` out 1 — one-cycle pulse on write of address `RAM_DEPTH`-1.

## Operation

- Commands (first byte in `IDLE`):
  - 0x2A CONF_WR.
  - 0x2C DATA_WR.
  - 0x00 NOP (stay in `IDLE`).
  - Any other value → `IGNORE`.
- States: `IDLE`, `CONF`, `HDR_HI`, `HDR_LO`, `DATA`, `IGNORE`.
- Transitions occur only on cycles with `byte_rdy_in`=1.
- `IDLE`:
  - 0x2A → `CONF`.
  - 0x2C → `DATA` (with `SPI_SEQ_ADDR_HDR_EN`: → `HDR_HI`). Write pointer loaded with 0.
  - 0x00 → `IDLE`.
  - Other → `IGNORE`.
- `CONF`: byte → `cfg_data_out`; pulse `cfg_wr_out`; → `IDLE`. Multiple commands per CS frame are legal.
- `DATA`:
  - Each byte: `ram_wr_en_out`=1, `ram_wr_addr_out`=ptr, `ram_wr_data_out`=byte; ptr+1.
  - If ptr == `RAM_DEPTH`-1: also pulse `frame_rdy_out`, then → `IDLE`. No wrap; further bytes are decoded as commands.
- Pointer arithmetic: `ADDR_WIDTH` bits; it never exceeds `RAM_DEPTH`-1 because of the transition above.
- `IGNORE`: absorbs all bytes until reset. No outputs toggle.
- Reset (`spi_rst_n`=0, any time, including mid-frame): state `IDLE`, ptr 0, all outputs 0, `cfg_data_out` 0x00. A partially written frame is left in RAM with no `frame_rdy_out`.
- `byte_rdy_in` pulses on consecutive cycles must each be processed; no byte is dropped.

## Timing

- All outputs are registered.
- Strobes and data are asserted the cycle after the `byte_rdy_in` cycle: latency 1.
- Strobes are high for exactly one cycle per accepted byte.
- `frame_rdy_out` coincides with the final `ram_wr_en_out`.
- `ram_wr_addr_out`/`ram_wr_data_out` are valid only when `ram_wr_en_out`=1; otherwise they hold their last value.
- Reset assertion clears outputs immediately (asynchronous). Deassertion takes effect on the next `clk_in` rise.

## Configuration

- `SPI_SEQ_ADDR_HDR_EN` defined:
  - DATA_WR is followed by a 2-byte big-endian start address (`HDR_HI`, then `HDR_LO`). Pointer = low `ADDR_WIDTH` bits of the 16-bit value.
  - If the value ≥ `RAM_DEPTH` → `IGNORE`.
  - Otherwise → `DATA`, starting at that address.
  - Header bytes produce no strobes.
- Undefined: `HDR_HI`/`HDR_LO` do not exist; DATA_WR payload always starts at address 0.

## Test plan

- Reset, then bytes 0x2A, 0x55 → one `cfg_wr_out` pulse with `cfg_data_out`=0x55 one cycle after the second `byte_rdy_in`; state returns to `IDLE`.
- 0x2C + 768 bytes (value = addr[7:0]) → 768 `ram_wr_en_out` pulses at addresses 0..767 with matching data; `frame_rdy_out` exactly once, with addr 767.
- 0x2C + 769 bytes, last = 0x2A, then 0x11 → 768 RAM writes; the 769th byte is decoded as CONF_WR, and the following byte gives `cfg_data_out`=0x11.
- 0x7F, 0x2A, 0x33 → no strobes at all (`IGNORE`); after `spi_rst_n` pulse, 0x2A, 0x33 → `cfg_wr_out` with 0x33.
- 0x2C + 10 bytes, `spi_rst_n` low, then 0x2C + 1 byte 0xAB → write to addr 0 data 0xAB; no `frame_rdy_out`.
- With `SPI_SEQ_ADDR_HDR_EN`:
  - 0x2C, 0x02, 0xFE, 0xA1, 0xA2 → writes addr 766=0xA1, 767=0xA2 with `frame_rdy_out`.
  - Header 0x03, 0x00 → `IGNORE`, no writes.

Source files
------------

// File: rtl/spi_byte_sequencer_if.sv
// rtl/spi_byte_sequencer_if.sv - byte stream in, config/pixel-RAM write ports out
interface spi_byte_sequencer_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  byte_rdy_in;
  logic [7:0]            byte_data_in;
  logic                  cfg_wr_out;
  logic [7:0]            cfg_data_out;
  logic                  ram_wr_en_out;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_out;
  logic [7:0]            ram_wr_data_out;
  logic                  frame_rdy_out;

  // Byte receiver side: supplies bytes, observes the decoded write ports.
  modport master (
    output byte_rdy_in, byte_data_in,
    input  cfg_wr_out, cfg_data_out, ram_wr_en_out, ram_wr_addr_out,
           ram_wr_data_out, frame_rdy_out
  );

  // Sequencer side.
  modport slave (
    input  byte_rdy_in, byte_data_in,
    output cfg_wr_out, cfg_data_out, ram_wr_en_out, ram_wr_addr_out,
           ram_wr_data_out, frame_rdy_out
  );
endinterface

// File: rtl/spi_byte_sequencer.sv
// rtl/spi_byte_sequencer.sv - SPI command decoder routing bytes to config register or pixel RAM (option: SPI_SEQ_ADDR_HDR_EN)
module spi_byte_sequencer #(
  parameter int RAM_DEPTH  = 768,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                clk_in,
  input  logic                spi_rst_n,
  spi_byte_sequencer_if.slave bus
);

  localparam logic [7:0] LP_CMD_CONF = 8'h2A;
  localparam logic [7:0] LP_CMD_DATA = 8'h2C;
  localparam logic [7:0] LP_CMD_NOP  = 8'h00;
  localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

`ifdef SPI_SEQ_ADDR_HDR_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CONF, S_HDR_HI, S_HDR_LO, S_DATA, S_IGNORE
  } state_t;
  localparam logic [16:0] LP_DEPTH_W = 17'(RAM_DEPTH);
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CONF, S_DATA, S_IGNORE
  } state_t;
`endif

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_cfg_wr;
  logic [7:0]            r_cfg_data;
  logic                  r_ram_wr_en;
  logic [ADDR_WIDTH-1:0] r_ram_wr_addr;
  logic [7:0]            r_ram_wr_data;
  logic                  r_frame_rdy;

`ifdef SPI_SEQ_ADDR_HDR_EN
  logic [7:0]  r_hdr_hi;
  logic [15:0] w_hdr_val;
  assign w_hdr_val = {r_hdr_hi, bus.byte_data_in};
`endif

  assign bus.cfg_wr_out      = r_cfg_wr;
  assign bus.cfg_data_out    = r_cfg_data;
  assign bus.ram_wr_en_out   = r_ram_wr_en;
  assign bus.ram_wr_addr_out = r_ram_wr_addr;
  assign bus.ram_wr_data_out = r_ram_wr_data;
  assign bus.frame_rdy_out   = r_frame_rdy;

  // Command/payload FSM; strobes default low so each accepted byte yields a single-cycle pulse.
  always_ff @(posedge clk_in or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_cfg_wr      <= 1'b0;
      r_cfg_data    <= 8'h00;
      r_ram_wr_en   <= 1'b0;
      r_ram_wr_addr <= '0;
      r_ram_wr_data <= 8'h00;
      r_frame_rdy   <= 1'b0;
`ifdef SPI_SEQ_ADDR_HDR_EN
      r_hdr_hi      <= 8'h00;
`endif
    end else begin
      r_cfg_wr    <= 1'b0;
      r_ram_wr_en <= 1'b0;
      r_frame_rdy <= 1'b0;
      if (bus.byte_rdy_in) begin
        case (r_state)
          S_IDLE: begin
            if (bus.byte_data_in == LP_CMD_CONF) begin
              r_state <= S_CONF;
            end else if (bus.byte_data_in == LP_CMD_DATA) begin
              r_ptr <= '0;
`ifdef SPI_SEQ_ADDR_HDR_EN
              r_state <= S_HDR_HI;
`else
              r_state <= S_DATA;
`endif
            end else if (bus.byte_data_in != LP_CMD_NOP) begin
              r_state <= S_IGNORE;
            end
          end
          S_CONF: begin
            r_cfg_data <= bus.byte_data_in;
            r_cfg_wr   <= 1'b1;
            r_state    <= S_IDLE;
          end
`ifdef SPI_SEQ_ADDR_HDR_EN
          S_HDR_HI: begin
            r_hdr_hi <= bus.byte_data_in;
            r_state  <= S_HDR_LO;
          end
          S_HDR_LO: begin
            // Out-of-range start addresses poison the rest of the CS frame.
            if ({1'b0, w_hdr_val} >= LP_DEPTH_W) begin
              r_state <= S_IGNORE;
            end else begin
              r_ptr   <= w_hdr_val[ADDR_WIDTH-1:0];
              r_state <= S_DATA;
            end
          end
`endif
          S_DATA: begin
            r_ram_wr_en   <= 1'b1;
            r_ram_wr_addr <= r_ptr;
            r_ram_wr_data <= bus.byte_data_in;
            // Last pixel byte closes the frame; no wrap, later bytes are commands again.
            if (r_ptr == LP_LAST_ADDR) begin
              r_frame_rdy <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
          S_IGNORE: begin
            r_state <= S_IGNORE;
          end
          default: begin
            r_state <= S_IGNORE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// tb/tb_spi_byte_sequencer.sv - randomized scoreboard bench for spi_byte_sequencer
module tb_spi_byte_sequencer;
  localparam int AW    = 10;
  localparam int DEPTH = 768;

  logic clk_in    = 1'b0;
  logic spi_rst_n = 1'b0;

  spi_byte_sequencer_if #(.ADDR_WIDTH(AW)) bus();

  spi_byte_sequencer #(.RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_in   (clk_in),
    .spi_rst_n(spi_rst_n),
    .bus      (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         is_cfg;
    bit         fr;
    int         addr;
    logic [7:0] data;
  } ev_t;

  ev_t        sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_hold = 8'h00;

  int m_kind[$];
  int m_addr[$];
  bit m_fr[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: parse one chip-select frame as a sequence of commands, tagging
  // each byte with the write it must cause (0 none, 1 config, 2 pixel RAM).
  task automatic model_frame(input logic [7:0] fr[$]);
    int n, i, k, v;
    logic [7:0] cmd;
    n = fr.size();
    m_kind.delete(); m_addr.delete(); m_fr.delete();
    for (int j = 0; j < n; j++) begin
      m_kind.push_back(0); m_addr.push_back(0); m_fr.push_back(1'b0);
    end
    i = 0;
    while (i < n) begin
      cmd = fr[i];
      i++;
      if (cmd == 8'h00) begin
        continue;
      end else if (cmd == 8'h2A) begin
        if (i < n) begin
          m_kind[i] = 1;
          i++;
        end
      end else if (cmd == 8'h2C) begin
        k = 0;
`ifdef SPI_SEQ_ADDR_HDR_EN
        if (i + 1 >= n) break;
        v = int'(fr[i]) * 256 + int'(fr[i+1]);
        i += 2;
        if (v >= DEPTH) break;
        k = v;
`else
        v = 0;
`endif
        while (i < n && k < DEPTH) begin
          m_kind[i] = 2;
          m_addr[i] = k;
          m_fr[i]   = (k == DEPTH - 1);
          i++;
          k++;
        end
      end else begin
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int max_gap);
    ev_t e;
    model_frame(fr);
    for (int i = 0; i < fr.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk_in); #1;
        bus.byte_rdy_in = 1'b0;
      end
      @(posedge clk_in); #1;
      bus.byte_rdy_in  = 1'b1;
      bus.byte_data_in = fr[i];
      if (m_kind[i] != 0) begin
        e.cyc    = cyc + 1;
        e.is_cfg = (m_kind[i] == 1);
        e.fr     = m_fr[i];
        e.addr   = m_addr[i];
        e.data   = fr[i];
        sb.push_back(e);
      end
    end
    @(posedge clk_in); #1;
    bus.byte_rdy_in = 1'b0;
  endtask

  // Chip-select deassert: drain, assert reset asynchronously mid-cycle, check outputs clear.
  task automatic cs_reset();
    repeat (3) @(posedge clk_in);
    check("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    #3 spi_rst_n = 1'b0;
    #1 check("reset_outputs",
             {bus.cfg_wr_out, bus.cfg_data_out, bus.ram_wr_en_out, bus.ram_wr_addr_out,
              bus.ram_wr_data_out, bus.frame_rdy_out}, 64'd0);
    exp_hold = 8'h00;
    @(negedge clk_in);
    spi_rst_n = 1'b1;
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (spi_rst_n && (bus.cfg_wr_out || bus.ram_wr_en_out || bus.frame_rdy_out)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got cfg_wr=%0b ram_wr_en=%0b frame_rdy=%0b addr=%0d expected no strobe (cycle %0d)",
                 bus.cfg_wr_out, bus.ram_wr_en_out, bus.frame_rdy_out, bus.ram_wr_addr_out, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("strobe_cycle", 64'(cyc), 64'(e.cyc));
        if (e.is_cfg) begin
          check("cfg_write", {bus.cfg_wr_out, bus.ram_wr_en_out, bus.frame_rdy_out, bus.cfg_data_out},
                {1'b1, 1'b0, 1'b0, e.data});
          exp_hold = e.data;
        end else begin
          check("ram_write", {bus.cfg_wr_out, bus.ram_wr_en_out, bus.frame_rdy_out, bus.ram_wr_addr_out,
                              bus.ram_wr_data_out, bus.cfg_data_out},
                {1'b0, 1'b1, e.fr, AW'(e.addr), e.data, exp_hold});
        end
      end
    end
  end

  initial begin
    logic [7:0] fr[$];
    int nseg, op, len, v;
    bus.byte_rdy_in  = 1'b0;
    bus.byte_data_in = 8'h00;
    repeat (2) @(posedge clk_in);
    #1 check("reset_outputs_init",
             {bus.cfg_wr_out, bus.cfg_data_out, bus.ram_wr_en_out, bus.ram_wr_addr_out,
              bus.ram_wr_data_out, bus.frame_rdy_out}, 64'd0);
    @(negedge clk_in);
    spi_rst_n = 1'b1;

    fr = '{8'h2A, 8'h55};
    send_frame(fr, 0);
    cs_reset();

`ifdef SPI_SEQ_ADDR_HDR_EN
    fr = '{8'h2C, 8'h00, 8'h00};
`else
    fr = '{8'h2C};
`endif
    for (int a = 0; a < DEPTH; a++) fr.push_back(8'(a));
    send_frame(fr, 0);
    cs_reset();

`ifdef SPI_SEQ_ADDR_HDR_EN
    fr = '{8'h2C, 8'h00, 8'h00};
`else
    fr = '{8'h2C};
`endif
    for (int a = 0; a < DEPTH; a++) fr.push_back(8'(a * 7));
    fr.push_back(8'h2A);
    fr.push_back(8'h11);
    send_frame(fr, 1);
    cs_reset();

    fr = '{8'h7F, 8'h2A, 8'h33};
    send_frame(fr, 1);
    cs_reset();
    fr = '{8'h2A, 8'h33};
    send_frame(fr, 1);
    cs_reset();

`ifdef SPI_SEQ_ADDR_HDR_EN
    fr = '{8'h2C, 8'h00, 8'h00};
`else
    fr = '{8'h2C};
`endif
    for (int a = 0; a < 10; a++) fr.push_back(8'($urandom));
    send_frame(fr, 0);
    cs_reset();
`ifdef SPI_SEQ_ADDR_HDR_EN
    fr = '{8'h2C, 8'h00, 8'h00, 8'hAB};
`else
    fr = '{8'h2C, 8'hAB};
`endif
    send_frame(fr, 0);
    cs_reset();

`ifdef SPI_SEQ_ADDR_HDR_EN
    fr = '{8'h2C, 8'h02, 8'hFE, 8'hA1, 8'hA2};
    send_frame(fr, 0);
    cs_reset();
    fr = '{8'h2C, 8'h03, 8'h00, 8'h12, 8'h2A, 8'h44};
    send_frame(fr, 0);
    cs_reset();
`endif

    repeat (30) begin
      fr.delete();
      nseg = $urandom_range(1, 4);
      repeat (nseg) begin
        op = $urandom_range(0, 7);
        case (op)
          0: fr.push_back(8'h00);
          1, 2: begin
            fr.push_back(8'h2A);
            fr.push_back(8'($urandom));
          end
          3, 4, 5: begin
            fr.push_back(8'h2C);
`ifdef SPI_SEQ_ADDR_HDR_EN
            v = ($urandom_range(0, 5) == 0) ? $urandom_range(700, 900) : $urandom_range(0, 40);
            fr.push_back(8'(v >> 8));
            fr.push_back(8'(v));
`else
            v = 0;
`endif
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(740, 780) : $urandom_range(0, 24);
            repeat (len) fr.push_back(8'($urandom));
          end
          default: begin
            fr.push_back(8'($urandom));
            repeat ($urandom_range(0, 3)) fr.push_back(8'($urandom));
          end
        endcase
      end
      send_frame(fr, 2);
      cs_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
